keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
- Upstream stage of the keylock datapath: drives the keypad row lines, samples the column lines, debounces and decodes the result.
- Presents a stable key code (`button`) and a held-level flag (`bstate`) to the controller, the key recorder and the digit sender.
- Also provides a one-cycle `key_strobe` per accepted press, so downstream stages need no edge detector of their own.

Parameters:
- SCAN_DIV, 12000, hwclk cycles each row is driven (1 ms at 12 MHz); minimum 4.
- DEBOUNCE_FRAMES, 20, consecutive identical scan frames required to accept a press or a release; minimum 2.

Ports:
- hwclk  input  1  system clock, 12 MHz.
- resetN  input  1  asynchronous active-low reset.
- keypad_r1  output  1  row 0 drive, active-low.
- keypad_r2  output  1  row 1 drive, active-low.
- keypad_r3  output  1  row 2 drive, active-low.
- keypad_c1  input  1  column 0 sense, active-low (external pull-up).
- keypad_c2  input  1  column 1 sense, active-low.
- keypad_c3  input  1  column 2 sense, active-low.
- button  output  4  code of the last accepted key.
- bstate  output  1  high while the accepted key is held.
- key_strobe  output  1  one-cycle pulse on each accepted press.

Behaviour:
- Clock and reset: one clock, hwclk. resetN is asynchronous and active-low.
- Reset values:
  - keypad_r1..r3 = 1 (all rows idle);
  - button = 4'hF (no key);
  - bstate = 0, key_strobe = 0;
  - all counters and synchronizers = 0 / idle.
- Row scanning:
  - Rows are driven low one at a time, order r1, r2, r3, then back to r1, each for SCAN_DIV cycles.
  - Exactly one row is low outside reset.
  - Scanning starts at r1 on the first cycle after resetN deasserts.
- Column sampling:
  - Columns pass through a 2-FF synchronizer.
  - The synchronized value is captured on the last cycle of each row slot.
- Frame:
  - One frame = 3 row slots = 3*SCAN_DIV cycles.
  - The frame code is evaluated on the last cycle of the r3 slot:
    - NONE: no closed contacts;
    - KEY(k): exactly one closed contact;
    - MULTI: two or more closed contacts.
- Key code: code = 3*row + col + 1, so keys are 1..9 (row and col both 0-based).
- Debounce:
  - A candidate register holds the previous frame code.
  - A count increments when the new frame code equals the candidate. On any mismatch the count is set to 1 and the candidate is reloaded with the new code.
  - A code is "stable" once the count reaches DEBOUNCE_FRAMES. The count saturates there.
- FSM, states IDLE and HELD:
  - IDLE → HELD when the stable code is KEY(k). In the following cycle: button = k, bstate = 1, key_strobe = 1 for exactly one cycle.
  - HELD → IDLE only when the stable code is NONE. bstate goes 0 the following cycle; button keeps its last value.
  - HELD with stable MULTI or a different KEY: no change. A new key is locked out until a full release.
  - IDLE with stable MULTI: no change, no strobe.
- Latency, with input stable and the contact opened/closed at an arbitrary cycle:
  - press → bstate rises no earlier than (DEBOUNCE_FRAMES-1)*3*SCAN_DIV cycles;
  - press → bstate rises no later than (DEBOUNCE_FRAMES+1)*3*SCAN_DIV + 3 cycles;
  - release → bstate falls within the same bounds.
- key_strobe coincides with the rising edge of bstate and is never high for two consecutive cycles.
- Reset mid-operation: outputs go to their reset values immediately and asynchronously; any debounce in progress is discarded.

Optional Feature:
- Macro: KEYPAD_ROW4_EN.
- When defined:
  - adds output keypad_r4 (active-low row 3);
  - scan order becomes r1..r4 and a frame is 4*SCAN_DIV cycles;
  - row 3 maps col0 = 4'd10 (*), col1 = 4'd0, col2 = 4'd11 (#);
  - latency bounds use 4*SCAN_DIV in place of 3*SCAN_DIV.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Bench setup: SCAN_DIV = 4, DEBOUNCE_FRAMES = 3 (frame = 12 cycles). The keypad model pulls column c low while the low row has key (row,c) closed.
1. Reset and scan order: hold resetN = 0 → r1..r3 = 111, button = F, bstate = 0. Release → r1 low cycles 1-4, r2 low 5-8, r3 low 9-12, then r1 again.
2. Clean press: close key 5 (row1,col1) for 120 cycles → bstate rises 24..51 cycles after closure, button = 5, key_strobe high exactly 1 cycle. Open the key → bstate falls within 24..51 cycles and button stays 5.
3. Bounce: toggle key 3 every 5 cycles for 60 cycles, then hold it closed → no strobe during the bounce; exactly one strobe afterwards with button = 3.
4. Multi-key: close keys 1 and 2 together for 120 cycles → bstate stays 0, no strobe, button = F.
5. Lockout: hold 7 until accepted, add 9, release 7 while keeping 9 → button stays 7, bstate stays 1, no strobe. Release 9 → bstate falls. Press 9 again → strobe with button = 9.
6. Reset during HELD: assert resetN while key 4 is held → bstate = 0 and rows = 111 immediately. Deassert with key 4 still closed → a fresh strobe after a full debounce window.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// 3x3 keypad row scanner with column synchronizer, frame decode and debounce.
// Define KEYPAD_ROW4_EN to add a fourth row (keypad_r4: *, 0, #).
module keypad_scan_debounce #(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic       hwclk,
    input  logic       resetN,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
`ifdef KEYPAD_ROW4_EN
    output logic       keypad_r4,
`endif
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_strobe
);

    // state   | meaning
    // IDLE    | no key accepted; waiting for a stable single key
    // HELD    | key accepted; waiting for a stable all-open frame

`ifdef KEYPAD_ROW4_EN
    localparam int NROWS = 4;
`else
    localparam int NROWS = 3;
`endif
    localparam int NKEYS = 3 * NROWS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    // Frame codes: bit 4 set marks the non-key codes.
    localparam logic [4:0] CODE_NONE  = 5'h10;
    localparam logic [4:0] CODE_MULTI = 5'h11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic                   scan_run;
    logic [DIV_W-1:0]       div_cnt;
    logic [1:0]             row_idx;
    logic                   slot_end;
    logic                   frame_end;
    logic [NROWS-1:0]       row_drv_n;
    logic [2:0]             col_sync1;
    logic [2:0]             col_sync2;
    logic [3*(NROWS-1)-1:0] row_hits;
    logic [NKEYS-1:0]       frame_bits;
    logic [4:0]             frame_code;
    logic                   key_seen;
    logic [4:0]             cand;
    logic [CNT_W-1:0]       deb_cnt;
    logic                   stable;
    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             button_nxt;
    logic                   strobe_nxt;

    assign slot_end  = scan_run && (div_cnt == '0);
    assign frame_end = slot_end && (row_idx == 2'(NROWS - 1));

    // scan_run holds the rows idle until the first cycle after reset.
    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            scan_run <= 1'b0;
            div_cnt  <= '0;
            row_idx  <= '0;
        end else if (!scan_run) begin
            scan_run <= 1'b1;
            div_cnt  <= DIV_W'(SCAN_DIV - 1);
        end else if (slot_end) begin
            div_cnt <= DIV_W'(SCAN_DIV - 1);
            row_idx <= frame_end ? 2'd0 : row_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    always_comb begin
        row_drv_n = '1;
        for (int r = 0; r < NROWS; r++) begin
            if (scan_run && (row_idx == 2'(r))) row_drv_n[r] = 1'b0;
        end
    end

    assign keypad_r1 = row_drv_n[0];
    assign keypad_r2 = row_drv_n[1];
    assign keypad_r3 = row_drv_n[2];
`ifdef KEYPAD_ROW4_EN
    assign keypad_r4 = row_drv_n[3];
`endif

    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            col_sync1 <= '0;
            col_sync2 <= '0;
        end else begin
            col_sync1 <= {keypad_c3, keypad_c2, keypad_c1};
            col_sync2 <= col_sync1;
        end
    end

    // The last row is never stored; it is decoded straight from the synchronizer.
    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            row_hits <= '0;
        end else if (slot_end) begin
            for (int r = 0; r < NROWS - 1; r++) begin
                if (row_idx == 2'(r)) row_hits[3*r +: 3] <= ~col_sync2;
            end
        end
    end

    function automatic logic [3:0] key_code(input int idx);
        logic [3:0] code;
        if (idx < 9) begin
            code = 4'(idx + 1);
        end else begin
            case (idx)
                9:       code = 4'd10;
                10:      code = 4'd0;
                default: code = 4'd11;
            endcase
        end
        return code;
    endfunction

    always_comb begin
        frame_bits = {~col_sync2, row_hits};
        frame_code = CODE_NONE;
        key_seen   = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (frame_bits[i]) begin
                frame_code = key_seen ? CODE_MULTI : {1'b0, key_code(i)};
                key_seen   = 1'b1;
            end
        end
    end

    assign stable = (deb_cnt == CNT_W'(DEBOUNCE_FRAMES));

    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            cand    <= CODE_NONE;
            deb_cnt <= '0;
        end else if (frame_end) begin
            if (frame_code == cand) begin
                if (!stable) deb_cnt <= deb_cnt + CNT_W'(1);
            end else begin
                cand    <= frame_code;
                deb_cnt <= CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        button_nxt = button;
        strobe_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stable && !cand[4]) begin
                    state_nxt  = ST_HELD;
                    button_nxt = cand[3:0];
                    strobe_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (stable && (cand == CODE_NONE)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            button     <= 4'hF;
            key_strobe <= 1'b0;
        end else begin
            state      <= state_nxt;
            button     <= button_nxt;
            key_strobe <= strobe_nxt;
        end
    end

    assign bstate = (state == ST_HELD);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a 3x3 contact-matrix model.
`timescale 1ns/1ps
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_FRAMES = 3;

    logic       hwclk = 1'b0;
    logic       resetN;
    logic       keypad_r1, keypad_r2, keypad_r3;
`ifdef KEYPAD_ROW4_EN
    logic       keypad_r4;
`endif
    logic       keypad_c1, keypad_c2, keypad_c3;
    logic [3:0] button;
    logic       bstate;
    logic       key_strobe;

    logic [8:0] keys;
    int         n_vec = 0;
    int         n_err = 0;
    int         strobe_cnt;
    logic       prev_strobe;

    always #5 hwclk = ~hwclk;

    keypad_scan_debounce #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) dut (
        .hwclk     (hwclk),
        .resetN    (resetN),
        .keypad_r1 (keypad_r1),
        .keypad_r2 (keypad_r2),
        .keypad_r3 (keypad_r3),
`ifdef KEYPAD_ROW4_EN
        .keypad_r4 (keypad_r4),
`endif
        .keypad_c1 (keypad_c1),
        .keypad_c2 (keypad_c2),
        .keypad_c3 (keypad_c3),
        .button    (button),
        .bstate    (bstate),
        .key_strobe(key_strobe)
    );

    // keys bit index = 3*row + col; a closed key pulls its column low while its row is low.
    always_comb begin
        keypad_c1 = !((!keypad_r1 && keys[0]) || (!keypad_r2 && keys[3]) || (!keypad_r3 && keys[6]));
        keypad_c2 = !((!keypad_r1 && keys[1]) || (!keypad_r2 && keys[4]) || (!keypad_r3 && keys[7]));
        keypad_c3 = !((!keypad_r1 && keys[2]) || (!keypad_r2 && keys[5]) || (!keypad_r3 && keys[8]));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hwclk);
        #1;
        if (key_strobe === 1'b1) begin
            strobe_cnt++;
            check("strobe_one_cycle", 32'(prev_strobe), 32'd0);
        end
        prev_strobe = key_strobe;
    endtask

    task automatic wait_bstate(input logic v, input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (bstate === v) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        int         exp_row;
        logic [2:0] exp_rows;
        logic       last_r1;
        logic       aligned;

        keys        = '0;
        resetN      = 1'b0;
        prev_strobe = 1'b0;
        strobe_cnt  = 0;

        // reset values and scan order
        repeat (3) @(posedge hwclk);
        #1;
        check("rst_rows", 32'({keypad_r3, keypad_r2, keypad_r1}), 32'h7);
        check("rst_button", 32'(button), 32'hF);
        check("rst_bstate", 32'(bstate), 32'd0);
        check("rst_strobe", 32'(key_strobe), 32'd0);
        @(negedge hwclk);
        resetN = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            exp_row  = ((cyc - 1) / 4) % 3;
            exp_rows = 3'b111;
            exp_rows[exp_row] = 1'b0;
            check("scan_rows", 32'({keypad_r3, keypad_r2, keypad_r1}), 32'(exp_rows));
        end

        // keys 1 and 2 together never produce a key
        keys       = 9'b000000011;
        strobe_cnt = 0;
        repeat (120) step();
        check("multi_bstate", 32'(bstate), 32'd0);
        check("multi_strobes", 32'(strobe_cnt), 32'd0);
        check("multi_button", 32'(button), 32'hF);
        keys = '0;
        repeat (60) step();

        // clean press and release of key 5
        keys[4]    = 1'b1;
        strobe_cnt = 0;
        wait_bstate(1'b1, 80, lat);
        check("press5_latency", 32'(lat >= 24 && lat <= 51), 32'd1);
        check("press5_strobe_at_rise", 32'(key_strobe), 32'd1);
        check("press5_button", 32'(button), 32'h5);
        repeat ((lat > 0) ? 120 - lat : 0) step();
        check("press5_strobes", 32'(strobe_cnt), 32'd1);
        keys[4] = 1'b0;
        wait_bstate(1'b0, 80, lat);
        check("release5_latency", 32'(lat >= 24 && lat <= 51), 32'd1);
        check("release5_button", 32'(button), 32'h5);
        check("release5_strobes", 32'(strobe_cnt), 32'd1);
        repeat (40) step();

        // key 3 bouncing with period 10, aligned so at most two closed frames in a row
        aligned = 1'b0;
        last_r1 = keypad_r1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (last_r1 && !keypad_r1) begin
                aligned = 1'b1;
                break;
            end
            last_r1 = keypad_r1;
        end
        check("bounce_align", 32'(aligned), 32'd1);
        strobe_cnt = 0;
        for (int d = 0; d < 60; d++) begin
            keys[2] = ((d % 10) < 5);
            step();
        end
        check("bounce_no_strobe", 32'(strobe_cnt), 32'd0);
        keys[2]    = 1'b1;
        strobe_cnt = 0;
        repeat (100) step();
        check("bounce_one_strobe", 32'(strobe_cnt), 32'd1);
        check("bounce_button", 32'(button), 32'h3);
        check("bounce_bstate", 32'(bstate), 32'd1);
        keys[2] = 1'b0;
        wait_bstate(1'b0, 80, lat);
        check("bounce_release_latency", 32'(lat >= 24 && lat <= 51), 32'd1);

        // lockout: 7 held, 9 added, 7 released
        keys[6]    = 1'b1;
        strobe_cnt = 0;
        wait_bstate(1'b1, 80, lat);
        check("lock7_button", 32'(button), 32'h7);
        keys[8] = 1'b1;
        repeat (60) step();
        keys[6] = 1'b0;
        repeat (60) step();
        check("lock_button_kept", 32'(button), 32'h7);
        check("lock_bstate_kept", 32'(bstate), 32'd1);
        check("lock_strobes", 32'(strobe_cnt), 32'd1);
        keys[8] = 1'b0;
        wait_bstate(1'b0, 80, lat);
        check("lock_release_latency", 32'(lat >= 24 && lat <= 51), 32'd1);
        keys[8]    = 1'b1;
        strobe_cnt = 0;
        wait_bstate(1'b1, 80, lat);
        check("press9_strobes", 32'(strobe_cnt), 32'd1);
        check("press9_button", 32'(button), 32'h9);
        keys[8] = 1'b0;
        wait_bstate(1'b0, 80, lat);
        check("release9_bstate", 32'(bstate), 32'd0);

        // reset while key 4 is held
        keys[3] = 1'b1;
        wait_bstate(1'b1, 80, lat);
        check("held4_button", 32'(button), 32'h4);
        resetN = 1'b0;
        #1;
        check("midrst_bstate", 32'(bstate), 32'd0);
        check("midrst_rows", 32'({keypad_r3, keypad_r2, keypad_r1}), 32'h7);
        check("midrst_button", 32'(button), 32'hF);
        check("midrst_strobe", 32'(key_strobe), 32'd0);
        repeat (2) @(posedge hwclk);
        @(negedge hwclk);
        resetN      = 1'b1;
        prev_strobe = 1'b0;
        strobe_cnt  = 0;
        lat         = -1;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (key_strobe === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("fresh_strobe_cycle", 32'(lat), 32'd38);
        check("fresh_bstate", 32'(bstate), 32'd1);
        check("fresh_button", 32'(button), 32'h4);
        repeat (10) step();
        check("fresh_strobes", 32'(strobe_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
